// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the multi-port integer register file.
// Consumers: reg_scoreboard, reg_file_sb.
package reg_file_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  // Architectural x0: hard-wired zero, never written, never pending.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, any writeback
// port retires it. A same-cycle issue beats a retire because the newly
// issued producer supersedes the one being written back.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WR     = 2,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  output logic [DEPTH-1:0]             busy_vec
);

  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] clr_s;
  logic [DEPTH-1:0] set_s;

  // Decode per-register set/clear requests and apply set-over-clear priority.
  always_comb begin
    clr_s  = '0;
    set_s  = '0;
    busy_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        clr_s[r] = clr_s[r] |
                   (wr_en[j] & (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)));
      end
      set_s[r]  = iss_en & (iss_addr == ADDR_WIDTH'(r));
      busy_d[r] = set_s[r] | (busy_q[r] & ~clr_s[r]);
    end
    // x0 can never be pending.
    busy_d[0] = 1'b0;
  end

  // Busy-bit state, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with integrated busy-bit scoreboard.
// Optional build macro: REG_FILE_BYPASS_EN enables write-through forwarding
// from the write ports to the read ports within the same cycle.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic [DEPTH-1:0]             busy_vec
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] ra_s;
  logic [DATA_WIDTH-1:0] rv_s;

  // Next array contents: ports applied in ascending order so the highest
  // index wins a same-address collision; x0 stays zero.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
      for (int j = 0; j < NUM_WR; j++) begin
        mem_d[r] = (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)))
                   ? wr_data[j*DATA_WIDTH +: DATA_WIDTH] : mem_d[r];
      end
    end
    mem_d[0] = '0;
  end

  // Register array storage, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes (with optional same-cycle forwarding) and busy lookup.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra_s    = '0;
    rv_s    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra_s = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rv_s = mem_q[ra_s];
`ifdef REG_FILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        rv_s = (wr_en[j] && (ra_s != ZERO_ADDR) &&
                (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra_s))
               ? wr_data[j*DATA_WIDTH +: DATA_WIDTH] : rv_s;
      end
`else
      rv_s = (ra_s == ZERO_ADDR) ? '0 : rv_s;
`endif
      // Forwarded write data must not leak out while reset is held.
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rst ? '0 : rv_s;
      rd_busy[i] = busy_vec[ra_s];
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR),
    .DEPTH      (DEPTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a register-array/busy-bit model
// updated per clock is compared on every falling edge, plus directed
// literal checks from the test plan. Honours REG_FILE_BYPASS_EN.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DP = 32;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [DP-1:0]     busy_vec;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem  [DP];
  logic          m_busy [DP];

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[j] = en;
    wr_addr[j*AW +: AW] = a;
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  function automatic logic [DW-1:0] rdd(input int i);
    return rd_data[i*DW +: DW];
  endfunction

  // Reference model: architectural state after each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DP; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
    end else begin
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_mem[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
      for (int j = 0; j < NW; j++)
        if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  end

  // Every falling edge: compare read ports and scoreboard with the model.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    logic [DP-1:0] bv;
    if (!$isunknown(rst)) begin
      for (int i = 0; i < NR; i++) begin
        a = rd_addr[i*AW +: AW];
        e = m_mem[a];
`ifdef REG_FILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
          if (wr_en[j] && a != 0 && wr_addr[j*AW +: AW] == a) e = wr_data[j*DW +: DW];
`endif
        if (rst) e = '0;
        chk($sformatf("model_rd_data[%0d]", i), 64'(rdd(i)), 64'(e));
        chk($sformatf("model_rd_busy[%0d]", i), 64'(rd_busy[i]), 64'(m_busy[a]));
      end
      for (int r = 0; r < DP; r++) bv[r] = m_busy[r];
      chk("model_busy_vec", 64'(busy_vec), 64'(bv));
    end
  end

  initial begin
    rst = 1'b0; rd_addr = '0; idle();
    #1 rst = 1'b1;
    #2;
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_busy_vec", 64'(busy_vec), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // x0 protection
    set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF); iss_en = 1'b1; iss_addr = 5'd0; set_rd(0, 5'd0);
    tick(); idle();
    chk("x0_read", 64'(rdd(0)), 64'd0);
    chk("x0_busy", 64'(busy_vec[0]), 64'd0);

    // Write collision: port 1 wins
    set_wr(0, 1'b1, 5'd3, 32'h1111_1111); set_wr(1, 1'b1, 5'd3, 32'h2222_2222);
    tick(); idle(); set_rd(0, 5'd3);
    #1 chk("collision_x3", 64'(rdd(0)), 64'h2222_2222);
    chk("collision_not_busy", 64'(rd_busy[0]), 64'd0);

    // Bypass / no-bypass visibility
    set_wr(0, 1'b1, 5'd9, 32'h0000_0001); tick(); idle();
    set_wr(1, 1'b1, 5'd9, 32'hCAFE_F00D); set_rd(0, 5'd9);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("bypass_same_cycle", 64'(rdd(0)), 64'hCAFE_F00D);
`else
    chk("nobypass_same_cycle", 64'(rdd(0)), 64'h0000_0001);
`endif
    tick(); idle();
    #1 chk("write_next_cycle", 64'(rdd(0)), 64'hCAFE_F00D);

    // Scoreboard lifecycle on x12
    set_rd(1, 5'd12); iss_en = 1'b1; iss_addr = 5'd12;
    #1 chk("busy_not_yet", 64'(rd_busy[1]), 64'd0);
    tick(); idle();
    chk("busy_cycle1", 64'(rd_busy[1]), 64'd1);
    iss_en = 1'b1; iss_addr = 5'd12; tick(); idle();
    chk("reissue_still_busy", 64'(rd_busy[1]), 64'd1);
    tick(); tick();
    set_wr(0, 1'b1, 5'd12, 32'h0000_0042);
    #1 chk("busy_same_cycle_write", 64'(rd_busy[1]), 64'd1);
    tick(); idle();
    chk("busy_released", 64'(rd_busy[1]), 64'd0);
    chk("busy_vec_clear", 64'(busy_vec), 64'd0);

    // Set-over-clear on x12
    iss_en = 1'b1; iss_addr = 5'd12; tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd12; set_wr(1, 1'b1, 5'd12, 32'h0000_00A5);
    tick(); idle();
    chk("set_over_clear_busy", 64'(rd_busy[1]), 64'd1);
    chk("set_over_clear_data", 64'(rdd(1)), 64'h0000_00A5);

    // Reset mid-run, between edges
    set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF); tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd7; tick(); idle();
    set_rd(0, 5'd5); set_rd(1, 5'd7);
    #1 chk("pre_reset_x5", 64'(rdd(0)), 64'hDEAD_BEEF);
    chk("pre_reset_busy7", 64'(rd_busy[1]), 64'd1);
    #1 rst = 1'b1;
    #1 chk("midreset_x5", 64'(rdd(0)), 64'd0);
    chk("midreset_busy_vec", 64'(busy_vec), 64'd0);
    #2 rst = 1'b0;
    tick();
    chk("post_reset_x5", 64'(rdd(0)), 64'd0);
    chk("post_reset_busy7", 64'(rd_busy[1]), 64'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
